// File: rtl/uart_rx_frontend.sv
`timescale 1ns/1ps
// uart_rx_frontend
// 16x oversampling UART byte receiver feeding a valid/ready byte consumer.
// Two-flop input synchroniser, free-running oversample tick, 2-of-3 majority
// sampling at mid-bit, start/stop validation and a first-word-fall-through
// output FIFO with sticky overrun reporting.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the
// eight data bits; without it parity_err is tied low and a frame is 10 bits.
module uart_rx_frontend #(
    parameter int OVS_DIV = 27,   // CLK cycles per oversample tick, >= 2
    parameter int FIFO_AW = 2     // FIFO depth = 2**FIFO_AW
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               rx_in,
    input  logic               rx_enable,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overrun,
    input  logic               clr_overrun
);

    localparam int TICK_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS_DIV - 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    // Receiver FSM encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [1:0] syncQ;
    logic       rxS;

    // Two-flop synchroniser; resets to the idle (high) line level.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            syncQ <= 2'b11;
        end else begin
            syncQ <= {syncQ[0], rx_in};
        end
    end

    assign rxS = syncQ[1];

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tickCnt;
    logic              tick;

    // Free-running divider while enabled, parked at 0 while disabled.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tickCnt <= '0;
        end else if (!rx_enable || (tickCnt == TICK_LAST)) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    assign tick = rx_enable && (tickCnt == TICK_LAST);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [2:0] state;
    logic [3:0] sCnt;       // oversample index within the current bit
    logic [2:0] bitIdx;     // data bit index, LSB first
    logic [7:0] shiftReg;   // assembled byte
    logic       samp7;      // line sample taken at sCnt = 7
    logic       samp8;      // line sample taken at sCnt = 8
    logic       maj;        // 2-of-3 vote; third sample is the live rxS at sCnt = 9
    logic       midTick;    // tick on which the bit value is decided
    logic       pushReq;    // good byte ready for the FIFO this cycle
    logic       frameHit;   // stop bit voted 0 this cycle
`ifdef UART_RX_PARITY_EN
    logic       parityBad;  // parity of the current frame already failed
    logic       parityHit;  // parity bit voted wrong this cycle
`endif

    // Bit decision and FSM-to-FIFO/error strobes.
    // NOTE: every signal gets an unconditional assignment here, so no latch can be inferred.
    always_comb begin
        maj      = (samp7 & samp8) | (samp7 & rxS) | (samp8 & rxS);
        midTick  = tick && (sCnt == 4'd9);
        frameHit = midTick && (state == ST_STOP) && !maj;
`ifdef UART_RX_PARITY_EN
        parityHit = midTick && (state == ST_PARITY) && (maj != ^shiftReg);
        pushReq   = midTick && (state == ST_STOP) && maj && !parityBad;
`else
        pushReq   = midTick && (state == ST_STOP) && maj;
`endif
    end

    // Frame sequencing: start validation, data shift, optional parity, stop check.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sCnt     <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            samp7    <= 1'b1;
            samp8    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parityBad <= 1'b0;
`endif
        end else if (!rx_enable) begin
            // Disabling abandons any partial frame.
            state  <= ST_IDLE;
            sCnt   <= '0;
            bitIdx <= '0;
        end else if (tick) begin
            if (sCnt == 4'd7) samp7 <= rxS;
            if (sCnt == 4'd8) samp8 <= rxS;
            sCnt <= sCnt + 4'd1;

            case (state)
                ST_IDLE: begin
                    sCnt <= '0;
                    if (!rxS) begin
                        state <= ST_START;
`ifdef UART_RX_PARITY_EN
                        parityBad <= 1'b0;
`endif
                    end
                end

                ST_START: begin
                    if ((sCnt == 4'd9) && maj) begin
                        // Line was high again at mid-bit: a glitch, not a start bit.
                        state <= ST_IDLE;
                        sCnt  <= '0;
                    end else if (sCnt == 4'd15) begin
                        state  <= ST_DATA;
                        bitIdx <= '0;
                    end
                end

                ST_DATA: begin
                    if (sCnt == 4'd9) shiftReg <= {maj, shiftReg[7:1]};
                    if (sCnt == 4'd15) begin
                        bitIdx <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (parityHit) parityBad <= 1'b1;
                    if (sCnt == 4'd15) state <= ST_STOP;
                end
`endif

                ST_STOP: begin
                    // Leave at mid stop bit so the next start edge is not missed.
                    if (sCnt == 4'd9) begin
                        state <= maj ? ST_IDLE : ST_BREAK;
                        sCnt  <= '0;
                    end
                end

                ST_BREAK: begin
                    // Wait out a held-low line before hunting for a start bit.
                    sCnt <= '0;
                    if (rxS) state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    sCnt  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error pulses
    // ------------------------------------------------------------------
    // Registered one-cycle error strobes.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= frameHit;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Registered one-cycle parity strobe.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parityHit;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr;
    logic [FIFO_AW-1:0] rdPtr;
    logic [FIFO_AW:0]   count;
    logic               pop;
    logic               full;
    logic               doPush;
    logic               dropByte;

    assign pop      = rx_valid && rx_ready;
    assign full     = (count == FULL_COUNT);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign doPush   = pushReq && (!full || pop);
    assign dropByte = pushReq && full && !pop;

    // Byte storage.
    // NOTE: the storage array is deliberately not reset; pointers and count say which entries are live.
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= shiftReg;
    end

    // Pointers wrap naturally at 2**FIFO_AW; count tracks occupancy exactly.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            case ({doPush, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (dropByte) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? mem[rdPtr] : 8'h00;
    assign fifo_count = count;

endmodule
